scrolling_seven_seg_display: RTL and testbench



---
 rtl/scrolling_seven_seg_display.sv | 125 ++++++++++++
 tb/tb_scrolling_seven_seg_display.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/scrolling_seven_seg_display.sv
// Scrolling hex display: ON/OFF scroll controller driving a multiplexed,
// common-anode 7-segment scanner with a shift-register digit store.
module scrolling_seven_seg_display #(
  parameter int unsigned DIGITS         = 8,
  parameter int unsigned REFRESH_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              on_off,
  input  logic              cnt_done,
  input  logic [4:0]        hex_char,
  output logic              cnt_start,
  output logic              next_char,
  output logic [DIGITS-1:0] anodes,
  output logic [7:0]        cathodes
);

  localparam int unsigned RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int unsigned KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [4:0]  BLANK = 5'h10;

  typedef enum logic {OFF, ON} state_t;

  state_t     state;
  logic       pend_write;
  logic [4:0] pend_char;
  logic [4:0] seg_data;
  logic       seg_off, seg_shift, seg_write, seg_clear;

  logic [4:0]    digit [DIGITS];
  logic [RW-1:0] ref_cnt;
  logic [KW-1:0] k;
  logic [4:0]    cur;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  // Turn-on is split over two cycles: clear first, then the captured character
  // is written on the following cycle via pend_write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= OFF;
      pend_write <= 1'b0;
      pend_char  <= '0;
      seg_data   <= BLANK;
      seg_off    <= 1'b1;
      seg_shift  <= 1'b0;
      seg_write  <= 1'b0;
      seg_clear  <= 1'b0;
      cnt_start  <= 1'b0;
      next_char  <= 1'b0;
    end else begin
      pend_write <= 1'b0;
      seg_shift  <= 1'b0;
      seg_write  <= 1'b0;
      seg_clear  <= 1'b0;
      cnt_start  <= 1'b0;
      next_char  <= 1'b0;
      case (state)
        OFF: begin
          seg_off <= 1'b1;
          if (on_off) begin
            state      <= ON;
            seg_off    <= 1'b0;
            seg_clear  <= 1'b1;
            pend_write <= 1'b1;
            pend_char  <= hex_char;
          end
        end
        default: begin
          seg_off <= 1'b0;
          if (on_off) begin
            state   <= OFF;
            seg_off <= 1'b1;
          end else if (pend_write || cnt_done) begin
            seg_shift <= 1'b1;
            seg_write <= 1'b1;
            seg_data  <= pend_write ? pend_char : hex_char;
            cnt_start <= 1'b1;
            next_char <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DIGITS; i++) digit[i] <= BLANK;
    end else if (seg_clear) begin
      for (int unsigned i = 0; i < DIGITS; i++) digit[i] <= BLANK;
    end else if (seg_shift || seg_write) begin
      if (seg_shift)
        for (int unsigned i = 1; i < DIGITS; i++) digit[i] <= digit[i-1];
      digit[0] <= seg_write ? seg_data : BLANK;
    end
  end

  assign cur = digit[k];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt  <= '0;
      k        <= '0;
      anodes   <= '1;
      cathodes <= '1;
    end else begin
      if (ref_cnt == RW'(REFRESH_CYCLES - 1)) begin
        ref_cnt <= '0;
        k       <= (k == KW'(DIGITS - 1)) ? '0 : k + 1'b1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
      anodes   <= seg_off ? '1 : ~(DIGITS'(1) << k);
      cathodes <= (seg_off || cur[4]) ? 8'hFF : {1'b1, seg7(cur[3:0])};
    end
  end

endmodule

// File: tb/tb_scrolling_seven_seg_display.sv
// Bench for scrolling_seven_seg_display: pulse-timing scoreboard plus per-frame
// cathode checks against a small digit model.
module tb_scrolling_seven_seg_display;
  logic       clk = 1'b0;
  logic       rst, on_off, cnt_done;
  logic [4:0] hex_char;
  logic       cnt_start, next_char;
  logic [7:0] anodes, cathodes;

  scrolling_seven_seg_display #(.DIGITS(8), .REFRESH_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .on_off(on_off), .cnt_done(cnt_done), .hex_char(hex_char),
    .cnt_start(cnt_start), .next_char(next_char), .anodes(anodes), .cathodes(cathodes)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int unsigned exp_q[$];
  logic [4:0] exp_d[8];
  logic       exp_on = 1'b0;
  logic [7:0] seg_tab[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Each cnt_start/next_char pulse must match the next expected cycle stamp.
  always @(negedge clk) begin
    if (!rst && (cnt_start || next_char)) begin
      chk("pulse_pair", {31'd0, cnt_start}, {31'd0, next_char});
      chk("pulse_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) chk("pulse_cycle", cyc, exp_q.pop_front());
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 8; i++) exp_d[i] = 5'h10;
  endtask

  task automatic model_push(input logic [4:0] v);
    for (int i = 7; i > 0; i--) exp_d[i] = exp_d[i-1];
    exp_d[0] = v;
  endtask

  function automatic logic [7:0] exp_cath(input int i);
    logic [4:0] d;
    d = exp_d[i];
    return d[4] ? 8'hFF : seg_tab[d[3:0]];
  endfunction

  task automatic pulse_cnt_done(input logic [4:0] c, input bit expect_write);
    @(negedge clk);
    hex_char = c;
    cnt_done = 1'b1;
    if (expect_write) begin
      exp_q.push_back(cyc + 1);
      model_push(c);
    end
    @(negedge clk);
    cnt_done = 1'b0;
  endtask

  task automatic pulse_on_off(input logic [4:0] c, input bit turning_on);
    @(negedge clk);
    hex_char = c;
    on_off   = 1'b1;
    exp_on   = turning_on;
    if (turning_on) begin
      exp_q.push_back(cyc + 2);
      model_clear();
      model_push(c);
    end
    @(negedge clk);
    on_off = 1'b0;
  endtask

  task automatic check_frame(input string name);
    logic [7:0] seen;
    int idx;
    seen = '0;
    repeat (4) @(negedge clk);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!exp_on) begin
        if (n == 0 || n == 21) begin
          chk({name, "_off_anodes"}, anodes, 8'hFF);
          chk({name, "_off_cathodes"}, cathodes, 8'hFF);
        end
      end else if ($onehot(~anodes)) begin
        idx = 0;
        for (int b = 0; b < 8; b++) if (!anodes[b]) idx = b;
        if (!seen[idx]) begin
          seen[idx] = 1'b1;
          chk($sformatf("%s_d%0d", name, idx), cathodes, exp_cath(idx));
        end
      end else begin
        chk({name, "_anodes_onehot"}, anodes, 8'hFE);
      end
    end
    if (exp_on) chk({name, "_frame_complete"}, seen, 8'hFF);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] seq[10] = '{5'h8, 5'h7, 5'h6, 5'h5, 5'h4, 5'h3, 5'h2, 5'h1, 5'h0, 5'hF};
    rst = 1'b1; on_off = 1'b0; cnt_done = 1'b0; hex_char = '0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_anodes", anodes, 8'hFF);
    chk("rst_cathodes", cathodes, 8'hFF);
    chk("rst_cnt_start", {31'd0, cnt_start}, 32'd0);
    chk("rst_next_char", {31'd0, next_char}, 32'd0);
    rst = 1'b0;

    // cnt_done while OFF
    repeat (3) pulse_cnt_done(5'h4, 1'b0);
    check_frame("off_idle");

    // turn on with 9
    pulse_on_off(5'h9, 1'b1);
    check_frame("on9");

    // scroll 8..0,F
    foreach (seq[i]) begin
      pulse_cnt_done(seq[i], 1'b1);
      check_frame($sformatf("scroll%0d", i));
    end

    // turn off, anodes blank from the next cycle
    pulse_on_off(5'h2, 1'b0);
    @(negedge clk);
    chk("off_next_cycle", anodes, 8'hFF);
    pulse_cnt_done(5'h1, 1'b0);
    check_frame("off_ignored");
    pulse_on_off(5'hA, 1'b1);
    check_frame("reon_A");

    // on_off and cnt_done together in ON
    @(negedge clk);
    hex_char = 5'h5; on_off = 1'b1; cnt_done = 1'b1; exp_on = 1'b0;
    @(negedge clk);
    on_off = 1'b0; cnt_done = 1'b0;
    check_frame("both_off");

    // blank character, then reset mid-scroll
    pulse_on_off(5'h3, 1'b1);
    pulse_cnt_done(5'h10, 1'b1);
    check_frame("blank");
    @(negedge clk);
    hex_char = 5'h7; cnt_done = 1'b1; rst = 1'b1;
    #1;
    chk("midrst_anodes", anodes, 8'hFF);
    chk("midrst_cathodes", cathodes, 8'hFF);
    chk("midrst_cnt_start", {31'd0, cnt_start}, 32'd0);
    chk("midrst_next_char", {31'd0, next_char}, 32'd0);
    @(negedge clk);
    cnt_done = 1'b0; rst = 1'b0; exp_on = 1'b0;
    model_clear();
    check_frame("after_rst");
    pulse_on_off(5'h4, 1'b1);
    check_frame("after_rst_on");

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
